// File: rtl/vend_dispense_sched_if.sv
// Panel-side handshake bundle for the shared dispense scheduler.
// The master side is the pair of front-end panels; the slave side is the scheduler.
interface vend_dispense_sched_if;
  logic [1:0] req;
  logic [1:0] item0;
  logic [1:0] item1;
  logic [2:0] chg0;
  logic [2:0] chg1;
  logic [1:0] gnt;
  logic [1:0] done;
  logic [1:0] short_chg;

  modport master (
    output req, item0, item1, chg0, chg1,
    input  gnt, done, short_chg
  );

  modport slave (
    input  req, item0, item1, chg0, chg1,
    output gnt, done, short_chg
  );
endinterface

// File: rtl/vend_dispense_sched.sv
// Round-robin scheduler sharing one dispense mechanism between two panels: sequences the
// item drop and coin payout against mech_ready and tracks the coin-tube inventory.
module vend_dispense_sched #(
  parameter int unsigned INV_W      = 6,
  parameter int unsigned INV_INIT5  = 20,
  parameter int unsigned INV_INIT10 = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vend_dispense_sched_if.slave pnl,
  input  logic                 mech_ready,
  output logic                 drop_water,
  output logic                 drop_coke,
  output logic                 drop_coffee,
  output logic                 change5,
  output logic                 change10,
  input  logic                 refill,
  output logic [INV_W-1:0]     cnt5,
  output logic [INV_W-1:0]     cnt10,
  output logic                 busy
);

  localparam logic [INV_W-1:0] Init5  = INV_INIT5[INV_W-1:0];
  localparam logic [INV_W-1:0] Init10 = INV_INIT10[INV_W-1:0];
  localparam logic [INV_W-1:0] One    = {{(INV_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {StIdle, StArb, StDrop, StGap, StChg, StDone} state_e;

  state_e           state_q, state_d;
  logic             win_q, win_d;
  logic             ptr_q, ptr_d;
  logic [1:0]       item_q, item_d;
  logic [2:0]       rem_q, rem_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic [1:0]       short_q, short_d;
  logic [2:0]       drop_q, drop_d;  // [0] water, [1] coke, [2] coffee
  logic             c5_q, c5_d;
  logic             c10_q, c10_d;
  logic [INV_W-1:0] cnt5_q, cnt5_d;
  logic [INV_W-1:0] cnt10_q, cnt10_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    item_d  = item_q;
    rem_d   = rem_q;
    gnt_d   = 2'b00;
    done_d  = 2'b00;
    short_d = 2'b00;
    drop_d  = 3'b000;
    c5_d    = 1'b0;
    c10_d   = 1'b0;
    cnt5_d  = cnt5_q;
    cnt10_d = cnt10_q;

    unique case (state_q)
      StIdle: begin
        if (pnl.req != 2'b00) begin
          // ptr_q names the panel that was not served last
          win_d   = (pnl.req == 2'b11) ? ptr_q : pnl.req[1];
          ptr_d   = ~win_d;
          item_d  = win_d ? pnl.item1 : pnl.item0;
          rem_d   = win_d ? pnl.chg1 : pnl.chg0;
          gnt_d   = 2'b01 << win_d;
          state_d = StArb;
        end
      end
      StArb: state_d = (item_q != 2'd0) ? StDrop : StChg;
      StDrop: begin
        if (mech_ready) begin
          drop_d  = {item_q == 2'd3, item_q == 2'd2, item_q == 2'd1};
          state_d = StGap;
        end
      end
      StGap: state_d = StChg;
      StChg: begin
        if (rem_q == 3'd0) begin
          done_d  = 2'b01 << win_q;
          state_d = StDone;
        end else if (mech_ready) begin
          if (rem_q >= 3'd2 && cnt10_q != '0) begin
            c10_d   = 1'b1;
            rem_d   = rem_q - 3'd2;
            cnt10_d = cnt10_q - One;
            state_d = StGap;
          end else if (cnt5_q != '0) begin
            c5_d    = 1'b1;
            rem_d   = rem_q - 3'd1;
            cnt5_d  = cnt5_q - One;
            state_d = StGap;
          end else begin
            // Out of usable coins: finish short rather than overpay with a 10
            done_d  = 2'b01 << win_q;
            short_d = 2'b01 << win_q;
            state_d = StDone;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (refill) begin
      cnt5_d  = Init5;
      cnt10_d = Init10;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      win_q   <= 1'b0;
      ptr_q   <= 1'b0;
      item_q  <= 2'd0;
      rem_q   <= 3'd0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      short_q <= 2'b00;
      drop_q  <= 3'b000;
      c5_q    <= 1'b0;
      c10_q   <= 1'b0;
      cnt5_q  <= Init5;
      cnt10_q <= Init10;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      item_q  <= item_d;
      rem_q   <= rem_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      short_q <= short_d;
      drop_q  <= drop_d;
      c5_q    <= c5_d;
      c10_q   <= c10_d;
      cnt5_q  <= cnt5_d;
      cnt10_q <= cnt10_d;
      busy_q  <= busy_d;
    end
  end

  assign pnl.gnt       = gnt_q;
  assign pnl.done      = done_q;
  assign pnl.short_chg = short_q;
  assign drop_water    = drop_q[0];
  assign drop_coke     = drop_q[1];
  assign drop_coffee   = drop_q[2];
  assign change5       = c5_q;
  assign change10      = c10_q;
  assign cnt5          = cnt5_q;
  assign cnt10         = cnt10_q;
  assign busy          = busy_q;

endmodule

// File: doc/vend_dispense_sched.md
Name: vend_dispense_sched

Overview:
Scheduler that shares one physical dispense mechanism between two vending front-end panels. Each panel's FSM requests an item drop and a change payout. The scheduler arbitrates round-robin between the panels and sequences drop and coin pulses against the mechanism's ready handshake. It also tracks the coin-tube inventory and picks the coin mix for each payout.

Parameters:
INV_W, 6, width of each coin-tube inventory counter
INV_INIT5, 20, reset/refill value of the 5-dollar coin counter
INV_INIT10, 20, reset/refill value of the 10-dollar coin counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  2  request per panel (bit i = panel i); held high until done[i]
item0, item1  input  2 each  item for panel 0/1: 0 none, 1 water, 2 coke, 3 coffee
chg0, chg1  input  3 each  change owed, in units of 5 dollars (0..5)
gnt  output  2  one-cycle grant pulse to the winning panel
done  output  2  one-cycle completion pulse to the served panel
short_chg  output  2  one-cycle pulse, coincident with done, when the payout was incomplete
mech_ready  input  1  mechanism can accept a pulse this cycle
drop_water, drop_coke, drop_coffee  output  1 each  one-cycle drop pulses
change5, change10  output  1 each  one-cycle coin-eject pulses
refill  input  1  pulse: reload both inventory counters to their INIT values
cnt5, cnt10  output  INV_W each  current coin inventory
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all pulse outputs, gnt, done, short_chg and busy are 0.
  - cnt5=INV_INIT5, cnt10=INV_INIT10; round-robin pointer selects panel 0 first.
  - Reset mid-operation abandons the transaction; nothing is replayed.
- All outputs are registered; every pulse is exactly one cycle wide.
- Request sampling:
  - req is sampled only in IDLE.
  - Panel item and chg inputs are latched on the IDLE->ARB transition.
  - Later changes to req, item or chg are ignored until the transaction returns to IDLE.
- Arbitration:
  - If only one panel requests, it wins.
  - If both request, the panel not served last wins; the pointer updates on grant.
- FSM states:
  - IDLE: on any req bit -> ARB.
  - ARB: gnt[win]=1 for this one cycle. Go to DROP if the latched item is nonzero, else CHG.
  - DROP: wait for mech_ready=1. In that cycle, pulse the drop line matching the item, then -> GAP.
  - GAP: one idle cycle with all pulses 0 -> CHG.
  - CHG:
    - If rem==0 -> DONE.
    - Else, wait for mech_ready=1, then apply the first rule that matches:
    - (a) rem>=2 and cnt10>0: change10 pulse, rem-=2, cnt10-=1.
    - (b) cnt5>0: change5 pulse, rem-=1, cnt5-=1.
    - (c) otherwise: set the short flag and go to DONE with no pulse.
    - After a pulse in (a) or (b) -> GAP.
    - Note: rem==1 with cnt5==0 is short even if cnt10>0; the block never overpays.
  - DONE: done[win]=1, and short_chg[win]=short flag. Clear the short flag -> IDLE.
- Pulse latency:
  - Minimum spacing between mechanism pulses is 2 cycles (pulse, GAP).
  - Any number of stall cycles while mech_ready=0 is tolerated, with no timeout.
- Inventory:
  - Counters never underflow, because they are decremented only when nonzero.
  - refill has priority over a same-cycle decrement and is accepted in any state.
- Item 0 with chg 0: ARB -> CHG -> DONE, with no mechanism pulses.

Test Plan:
- Single request: panel 0 asks for coke with chg=3 and mech_ready held at 1. Required response:
  - gnt=01, then a drop_coke pulse.
  - Then change10 and change5 pulses, each 2 cycles apart.
  - Then done=01 with short_chg=00, and cnt10=19, cnt5=19.
- Both panels request in the same cycle after reset. Required response:
  - Panel 0 is granted first.
  - Panel 1 is granted on the next IDLE.
  - When both request again, panel 0 is granted again (alternation).
- Stall: mech_ready=0 for 7 cycles during DROP. The drop pulse appears in the first cycle mech_ready=1, and no pulse appears earlier.
- Short change: cnt5=0, cnt10=1, chg=3. Required response:
  - One change10 pulse, then done together with short_chg.
  - cnt10=0 afterwards.
- rem=1, cnt5=0, cnt10=5. Required response: no coin pulse, short_chg=1, cnt10 stays 5.
- Async reset asserted mid-CHG. Outputs go to 0 immediately; counters reload to 20/20; after release, a pending req0 is granted cleanly.
